// File: rtl/load_writeback_if.sv
// Purpose: bundle of the load-command, memory-bus and register-file writeback
//          signals of load_writeback.
// Ports (slave = load unit view):
//   command   : start, addr, size, is_signed, dst        (in)
//   status    : busy                                     (out)
//   memory    : mem_addr, mem_rd (out); mem_rdata, mem_ack (in)
//   writeback : wa, wd, we_l, we_h, done                 (out)
//   fault     : err, err_cause                           (out)
interface load_writeback_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              is_signed;
  logic [2:0]        dst;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [15:0]       mem_rdata;
  logic              mem_ack;
  logic [2:0]        wa;
  logic [31:0]       wd;
  logic              we_l;
  logic              we_h;
  logic              done;
  logic              err;
  logic [1:0]        err_cause;

  // Load unit side
  modport slave (
    input  start, addr, size, is_signed, dst, mem_rdata, mem_ack,
    output busy, mem_addr, mem_rd, wa, wd, we_l, we_h, done, err, err_cause
  );

  // Command issuer / memory model side
  modport master (
    output start, addr, size, is_signed, dst, mem_rdata, mem_ack,
    input  busy, mem_addr, mem_rd, wa, wd, we_l, we_h, done, err, err_cause
  );
endinterface

// File: rtl/load_writeback.sv
// Purpose: multi-cycle load unit. Takes one byte/halfword/word load command,
//          fetches it over a 16-bit variable-latency memory bus (two beats for
//          a word), sign/zero-extends it and issues a single register-file
//          writeback cycle. Misaligned accesses and bus timeouts abort with an
//          ERR pulse instead.
// Ports:
//   clk    : clock, all state on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : load_writeback_if.slave (command, memory bus, writeback, fault)
// Parameters:
//   ADDR_W  : load / memory address width
//   TIMEOUT : cycles a request may wait for mem_ack before abort (1..1023)
module load_writeback #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  load_writeback_if.slave  bus
);

  localparam int unsigned      CNT_W          = 10;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       SZ_BYTE        = 2'b00;
  localparam logic [1:0]       SZ_HALF        = 2'b01;
  localparam logic [1:0]       SZ_WORD        = 2'b10;
  localparam logic [1:0]       CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0]       CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_LO,
    ST_REQ_HI,
    ST_WB,
    ST_FAULT
  } state_e;

  state_e              state_q,     state_d;
  logic [1:0]          size_q,      size_d;
  logic                lane_q,      lane_d;
  logic                signed_q,    signed_d;
  logic [2:0]          dst_q,       dst_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [15:0]         lo_q,        lo_d;
  logic                busy_q,      busy_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic                mem_rd_q,    mem_rd_d;
  logic [2:0]          wa_q,        wa_d;
  logic [31:0]         wd_q,        wd_d;
  logic                we_l_q,      we_l_d;
  logic                we_h_q,      we_h_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;
  logic [1:0]          err_cause_q, err_cause_d;

  // Alignment rule: halfword needs bit0 clear, word needs bits1:0 clear,
  // the reserved size code is always rejected.
  function automatic logic misaligned_f(input logic [1:0] size,
                                        input logic [1:0] lsb);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lsb[0];
      SZ_WORD: bad = (lsb != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Byte/halfword result from one bus beat; byte lane picked by address bit 0.
  function automatic logic [31:0] extend_f(input logic [15:0] raw,
                                           input logic [1:0]  size,
                                           input logic        lane,
                                           input logic        sgn);
    logic [7:0]  b;
    logic [31:0] r;
    b = lane ? raw[15:8] : raw[7:0];
    if (size == SZ_BYTE) begin
      r = {{24{sgn & b[7]}}, b};
    end else begin
      r = {{16{sgn & raw[15]}}, raw};
    end
    return r;
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    lane_d      = lane_q;
    signed_d    = signed_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = mem_rd_q;
    wa_d        = wa_q;
    wd_d        = wd_q;
    err_cause_d = err_cause_q;
    we_l_d      = 1'b0;
    we_h_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          size_d   = bus.size;
          lane_d   = bus.addr[0];
          signed_d = bus.is_signed;
          dst_d    = bus.dst;
          if (misaligned_f(bus.size, bus.addr[1:0])) begin
            state_d     = ST_FAULT;
            err_d       = 1'b1;
            err_cause_d = CAUSE_MISALIGN;
          end else begin
            state_d    = ST_REQ_LO;
            mem_addr_d = {bus.addr[ADDR_W-1:1], 1'b0};
            mem_rd_d   = 1'b1;
            cnt_d      = '0;
          end
        end
      end

      ST_REQ_LO: begin
        // An ack in the timeout cycle is checked first, so it wins.
        if (bus.mem_ack) begin
          lo_d = bus.mem_rdata;
          if (size_q == SZ_WORD) begin
            // Back-to-back second beat, no idle cycle on the bus
            state_d    = ST_REQ_HI;
            mem_addr_d = mem_addr_q + ADDR_W'(2);
            cnt_d      = '0;
          end else begin
            state_d  = ST_WB;
            mem_rd_d = 1'b0;
            we_l_d   = 1'b1;
            we_h_d   = 1'b1;
            done_d   = 1'b1;
            wa_d     = dst_q;
            wd_d     = extend_f(bus.mem_rdata, size_q, lane_q, signed_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_FAULT;
          mem_rd_d    = 1'b0;
          err_d       = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REQ_HI: begin
        if (bus.mem_ack) begin
          state_d  = ST_WB;
          mem_rd_d = 1'b0;
          we_l_d   = 1'b1;
          we_h_d   = 1'b1;
          done_d   = 1'b1;
          wa_d     = dst_q;
          wd_d     = {bus.mem_rdata, lo_q};
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_FAULT;
          mem_rd_d    = 1'b0;
          err_d       = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WB:    state_d = ST_IDLE;
      ST_FAULT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= 2'b00;
      lane_q      <= 1'b0;
      signed_q    <= 1'b0;
      dst_q       <= 3'd0;
      cnt_q       <= '0;
      lo_q        <= 16'h0000;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      wa_q        <= 3'd0;
      wd_q        <= 32'h0000_0000;
      we_l_q      <= 1'b0;
      we_h_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      signed_q    <= signed_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      we_l_q      <= we_l_d;
      we_h_q      <= we_h_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.wa        = wa_q;
  assign bus.wd        = wd_q;
  assign bus.we_l      = we_l_q;
  assign bus.we_h      = we_h_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_cause = err_cause_q;

endmodule

// File: tb/tb_load_writeback.sv
// Scoreboard bench for load_writeback: expected writeback/fault responses are
// queued when a load is issued and popped by a monitor whenever the DUT
// presents DONE/ERR/WE. A second instance with TIMEOUT=4 covers the timeout.
module tb_load_writeback;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_writeback_if #(.ADDR_W(32)) b ();
  load_writeback_if #(.ADDR_W(32)) b2 ();

  load_writeback #(.ADDR_W(32), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  load_writeback #(.ADDR_W(32), .TIMEOUT(4)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  typedef struct packed {
    logic        is_err;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [1:0]  cause;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp2_q[$];
  int          checks = 0;
  int          errors = 0;

  // Memory responder state
  int          ack_delay = 0;
  int          req_cnt   = 0;
  int          last_len  = 0;
  int          req_len   = 0;
  logic        in_req    = 1'b0;
  logic [31:0] req_addr  = 32'h0;
  logic [31:0] addr_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'h100: return 16'h5678;
      32'h102: return 16'h1234;
      32'h200: return 16'hA07F;
      32'h300: return 16'h8001;
      32'h400: return 16'hBEEF;
      32'h402: return 16'hCAFE;
      default: return 16'hDEAD;
    endcase
  endfunction

  task automatic check_item(input string tag, input exp_t e,
                            input logic done, input logic err,
                            input logic we_l, input logic we_h,
                            input logic [2:0] wa, input logic [31:0] wd,
                            input logic [1:0] cause);
    if (!e.is_err) begin
      chk({tag, "_wb_flags"}, {28'd0, done, err, we_l, we_h}, 32'hB);
      chk({tag, "_wa"}, 32'(wa), 32'(e.wa));
      chk({tag, "_wd"}, wd, e.wd);
    end else begin
      chk({tag, "_err_flags"}, {28'd0, done, err, we_l, we_h}, 32'h4);
      chk({tag, "_err_cause"}, 32'(cause), 32'(e.cause));
    end
  endtask

  // Memory model: acks after ack_delay wait cycles, checks address stability
  always @(negedge clk) begin
    if (rst_n !== 1'b1 || b.mem_rd !== 1'b1) begin
      b.mem_ack   = 1'b0;
      b.mem_rdata = 16'h0000;
      in_req      = 1'b0;
    end else begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = b.mem_addr;
        req_len  = 0;
        addr_log.push_back(b.mem_addr);
        req_cnt++;
      end
      req_len++;
      chk("mem_addr_stable", b.mem_addr, req_addr);
      if (req_len > ack_delay) begin
        b.mem_ack   = 1'b1;
        b.mem_rdata = mem_word(b.mem_addr);
        in_req      = 1'b0;
        last_len    = req_len;
      end else begin
        b.mem_ack = 1'b0;
      end
    end
  end

  // Monitor: main instance
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (rst_n === 1'b1 && (b.done || b.err || b.we_l || b.we_h)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_main", {29'd0, b.done, b.err, b.we_l | b.we_h}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_item("main", e, b.done, b.err, b.we_l, b.we_h, b.wa, b.wd, b.err_cause);
      end
    end
  end

  // Monitor: timeout instance
  always @(negedge clk) begin : mon_to
    exp_t e;
    if (rst_n === 1'b1 && (b2.done || b2.err || b2.we_l || b2.we_h)) begin
      if (exp2_q.size() == 0) begin
        chk("unexpected_out_to", {29'd0, b2.done, b2.err, b2.we_l | b2.we_h}, 32'd0);
      end else begin
        e = exp2_q.pop_front();
        check_item("to", e, b2.done, b2.err, b2.we_l, b2.we_h, b2.wa, b2.wd, b2.err_cause);
      end
    end
  end

  // Issue one load, push its expected response, check latency and idle-after.
  // poke re-asserts START while the unit is busy; it must be ignored.
  task automatic run_load(input logic [31:0] addr, input logic [1:0] size,
                          input logic sgn, input logic [2:0] dst,
                          input logic is_err, input logic [31:0] wd,
                          input logic [1:0] cause, input int lat, input bit poke);
    int   cyc;
    bit   got;
    exp_t e;
    e.is_err = is_err;
    e.wa     = dst;
    e.wd     = wd;
    e.cause  = cause;
    exp_q.push_back(e);
    @(negedge clk);
    b.start     = 1'b1;
    b.addr      = addr;
    b.size      = size;
    b.is_signed = sgn;
    b.dst       = dst;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        b.start = poke;
        b.addr  = 32'h200;
        b.size  = 2'b00;
        b.dst   = 3'd7;
      end
      if (cyc == 2) b.start = 1'b0;
      if (b.done === 1'b1 || b.err === 1'b1) got = 1'b1;
    end
    chk("latency", 32'(cyc), 32'(lat));
    @(negedge clk);
    chk("busy_after", 32'(b.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, rd, cyc;
    bit   got;
    exp_t e;

    rst_n        = 1'b0;
    b.start      = 1'b0;
    b.addr       = 32'h0;
    b.size       = 2'b00;
    b.is_signed  = 1'b0;
    b.dst        = 3'd0;
    b2.start     = 1'b0;
    b2.addr      = 32'h0;
    b2.size      = 2'b00;
    b2.is_signed = 1'b0;
    b2.dst       = 3'd0;
    b2.mem_ack   = 1'b0;
    b2.mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_busy",     32'(b.busy), 32'd0);
    chk("rst_mem_rd",   32'(b.mem_rd), 32'd0);
    chk("rst_mem_addr", b.mem_addr, 32'd0);
    chk("rst_wa_wd",    b.wd | 32'(b.wa), 32'd0);
    chk("rst_strobes",  {28'd0, b.we_l, b.we_h, b.done, b.err}, 32'd0);
    chk("rst_err_cause", 32'(b.err_cause), 32'd0);
    rst_n = 1'b1;

    // Word, ack with each request
    ack_delay = 0;
    addr_log.delete();
    run_load(32'h100, 2'b10, 1'b0, 3'd3, 1'b0, 32'h12345678, 2'b00, 3, 1'b0);
    chk("word_beats", 32'(addr_log.size()), 32'd2);
    chk("word_addr_lo", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h100);
    chk("word_addr_hi", addr_log.size() > 1 ? addr_log[1] : 32'hFFFF_FFFF, 32'h102);

    // Bytes from halfword 0xA07F
    addr_log.delete();
    run_load(32'h201, 2'b00, 1'b1, 3'd1, 1'b0, 32'hFFFFFFA0, 2'b00, 2, 1'b0);
    chk("byte_hi_beats", 32'(addr_log.size()), 32'd1);
    chk("byte_hi_addr", addr_log.size() > 0 ? addr_log[0] : 32'hFFFF_FFFF, 32'h200);
    addr_log.delete();
    run_load(32'h200, 2'b00, 1'b0, 3'd2, 1'b0, 32'h0000007F, 2'b00, 2, 1'b0);
    chk("byte_lo_beats", 32'(addr_log.size()), 32'd1);

    // Halfword 0x8001 with a 5-cycle ack delay
    ack_delay = 5;
    run_load(32'h300, 2'b01, 1'b1, 3'd4, 1'b0, 32'hFFFF8001, 2'b00, 7, 1'b0);
    chk("half_s_rd_cycles", 32'(last_len), 32'd6);
    run_load(32'h300, 2'b01, 1'b0, 3'd6, 1'b0, 32'h00008001, 2'b00, 7, 1'b0);
    chk("half_u_rd_cycles", 32'(last_len), 32'd6);

    // Misaligned: word at 0x102, halfword at 0x301, reserved size
    ack_delay = 0;
    n = req_cnt;
    run_load(32'h102, 2'b10, 1'b0, 3'd5, 1'b1, 32'h0, 2'b01, 1, 1'b0);
    run_load(32'h301, 2'b01, 1'b1, 3'd5, 1'b1, 32'h0, 2'b01, 1, 1'b0);
    run_load(32'h200, 2'b11, 1'b0, 3'd5, 1'b1, 32'h0, 2'b01, 1, 1'b0);
    chk("misalign_no_bus", 32'(req_cnt), 32'(n));
    chk("misalign_cause_held", 32'(b.err_cause), 32'd1);

    // Timeout instance: no ack, then a late ack must not write
    e.is_err = 1'b1;
    e.wa     = 3'd0;
    e.wd     = 32'h0;
    e.cause  = 2'b10;
    exp2_q.push_back(e);
    @(negedge clk);
    b2.start = 1'b1;
    b2.addr  = 32'h500;
    b2.size  = 2'b10;
    b2.dst   = 3'd1;
    rd  = 0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b2.start = 1'b0;
      if (b2.mem_rd === 1'b1) rd++;
      if (b2.err === 1'b1) got = 1'b1;
    end
    chk("to_rd_cycles", 32'(rd), 32'd4);
    chk("to_latency", 32'(cyc), 32'd5);
    b2.mem_ack   = 1'b1;
    b2.mem_rdata = 16'h1111;
    repeat (4) begin
      @(negedge clk);
      chk("to_late_ack_quiet", {28'd0, b2.we_l, b2.we_h, b2.done, b2.mem_rd}, 32'd0);
    end
    b2.mem_ack = 1'b0;
    chk("to_cause_held", 32'(b2.err_cause), 32'd2);

    // Reset during REQ_HI of a word load
    ack_delay = 3;
    @(negedge clk);
    b.start = 1'b1;
    b.addr  = 32'h400;
    b.size  = 2'b10;
    b.dst   = 3'd5;
    @(negedge clk);
    b.start = 1'b0;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (b.mem_rd === 1'b1 && b.mem_addr === 32'h402) got = 1'b1;
    end
    chk("reached_req_hi", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_rd", 32'(b.mem_rd), 32'd0);
    chk("rst_mid_we", {30'd0, b.we_l, b.we_h}, 32'd0);
    chk("rst_mid_busy", 32'(b.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fresh word load after reset; START pulsed while busy is ignored
    ack_delay = 0;
    run_load(32'h400, 2'b10, 1'b0, 3'd5, 1'b0, 32'hCAFEBEEF, 2'b00, 3, 1'b1);

    repeat (5) @(negedge clk);
    chk("main_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("to_queue_drained", 32'(exp2_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
